// File: rtl/cone_bist_driver.sv
// BIST driver for a generated logic cone: sources patterns, compacts responses into a 16-bit MISR.
// Define CONE_BIST_EXHAUSTIVE_EN to replace the LFSR source with an exhaustive N_IN-bit up-counter.
//
// state | meaning
// IDLE  | waiting for start, MISR cleared, pat_o driven to 0
// RUN   | applying patterns, absorbing one response per clock
// DONE  | signature held and compared against golden_i
module cone_bist_driver #(
    parameter int unsigned N_IN      = 5,
    parameter int unsigned N_OUT     = 1,
    parameter int unsigned PAT_COUNT = 32,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_OUT-1:0]  resp_i,
    input  logic [15:0]       golden_i,
    output logic [N_IN-1:0]   pat_o,
    output logic              busy,
    output logic              done,
    output logic [15:0]       signature,
    output logic              pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef CONE_BIST_EXHAUSTIVE_EN
    localparam logic [15:0] LAST_CNT = 16'((32'd1 << N_IN) - 32'd1);
`else
    localparam logic [15:0] LAST_CNT = 16'(PAT_COUNT - 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
`endif

    // Shared tap set x^16+x^14+x^13+x^11+1 for both the LFSR and the MISR.
    function automatic logic [15:0] step16(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] cnt_q, cnt_d;
`ifndef CONE_BIST_EXHAUSTIVE_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            misr_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
`ifndef CONE_BIST_EXHAUSTIVE_EN
            lfsr_q  <= SEED_EFF;
`endif
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
`ifndef CONE_BIST_EXHAUSTIVE_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
`ifndef CONE_BIST_EXHAUSTIVE_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    misr_d  = 16'h0000;
                    cnt_d   = 16'h0000;
`ifndef CONE_BIST_EXHAUSTIVE_EN
                    lfsr_d  = SEED_EFF;
`endif
                end
            end
            RUN: begin
                // abort wins over the terminal count and suppresses the absorb
                if (abort) begin
                    state_d = IDLE;
                    misr_d  = 16'h0000;
                end else begin
                    misr_d = step16(misr_q) ^ 16'(resp_i);
                    cnt_d  = cnt_q + 16'd1;
`ifndef CONE_BIST_EXHAUSTIVE_EN
                    lfsr_d = step16(lfsr_q);
`endif
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pat_o = '0;
        if (state_q == RUN) begin
`ifdef CONE_BIST_EXHAUSTIVE_EN
            pat_o = cnt_q[N_IN-1:0];
`else
            pat_o = lfsr_q[N_IN-1:0];
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign signature = misr_q;
    assign pass      = done && (misr_q == golden_i);

endmodule

// File: tb/tb_cone_bist_driver.sv
// Scoreboard bench for cone_bist_driver: expected patterns and signatures are queued at start
// and popped as the DUT applies patterns and reaches DONE.
module tb_cone_bist_driver;

    localparam int N_IN = 5;
`ifdef CONE_BIST_EXHAUSTIVE_EN
    localparam int PC       = 7;
    localparam int EXP_LEN  = 32;
    localparam int EXP_LEN1 = 32;
`else
    localparam int PC       = 32;
    localparam int EXP_LEN  = 32;
    localparam int EXP_LEN1 = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [0:0]      resp;
    logic [15:0]     golden = 16'h0000;
    logic [N_IN-1:0] pat_o;
    logic            busy, done, pass;
    logic [15:0]     signature;

    logic            start1 = 1'b0;
    logic            abort1 = 1'b0;
    logic [0:0]      resp1;
    logic [15:0]     golden1 = 16'h0000;
    logic [N_IN-1:0] pat_o1;
    logic            busy1, done1, pass1;
    logic [15:0]     signature1;

    int resp_mode = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [N_IN-1:0] pat_q[$];
    logic [15:0]     sig_q[$];

    always #5 clk = ~clk;

    cone_bist_driver #(.N_IN(N_IN), .N_OUT(1), .PAT_COUNT(PC), .SEED(16'hACE1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp_i(resp),
        .golden_i(golden), .pat_o(pat_o), .busy(busy), .done(done),
        .signature(signature), .pass(pass)
    );

    cone_bist_driver #(.N_IN(N_IN), .N_OUT(1), .PAT_COUNT(1), .SEED(16'hACE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .resp_i(resp1),
        .golden_i(golden1), .pat_o(pat_o1), .busy(busy1), .done(done1),
        .signature(signature1), .pass(pass1)
    );

    function automatic logic cone_fn(input logic [N_IN-1:0] p);
        return (^(p & 5'b10110)) ^ (p[0] & p[3]);
    endfunction

    always_comb begin
        case (resp_mode)
            0:       resp = 1'b0;
            1:       resp = 1'b1;
            default: resp = cone_fn(pat_o);
        endcase
    end
    assign resp1 = 1'b1;

    function automatic logic [15:0] poly_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pattern stream plus signature for a run of len patterns.
    task automatic model_run(input int len, input int mode, input bit push_pats);
        logic [15:0]     l, m;
        logic [N_IN-1:0] p;
        logic            r;
        l = 16'hACE1;
        m = 16'h0000;
        for (int k = 0; k < len; k++) begin
`ifdef CONE_BIST_EXHAUSTIVE_EN
            p = N_IN'(k);
`else
            p = l[N_IN-1:0];
`endif
            if (push_pats) pat_q.push_back(p);
            r = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : cone_fn(p);
            m = poly_step(m) ^ {15'h0000, r};
            l = poly_step(l);
        end
        sig_q.push_back(m);
    endtask

    task automatic do_run(input int mode, input int start_at, input int abort_at);
        int          cycles;
        logic [15:0] exp_sig;
        resp_mode = mode;
        model_run(EXP_LEN, mode, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            if (pat_q.size() > 0) check("pat_o", 32'(pat_o), 32'(pat_q.pop_front()));
            else check("pat_q_underflow", 32'(cycles), 32'(EXP_LEN));
`ifndef CONE_BIST_EXHAUSTIVE_EN
            if (cycles == 1) check("pat_first", 32'(pat_o), 32'h01);
            if (cycles == 2) check("pat_second", 32'(pat_o), 32'h03);
`endif
            start = (cycles == start_at);
            abort = (cycles == abort_at);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        exp_sig = sig_q.pop_front();
        check("busy_end", 32'(busy), 32'd0);
        check("pat_o_idle", 32'(pat_o), 32'd0);
        if (abort_at > 0) begin
            pat_q.delete();
            check("abort_cycles", 32'(cycles), 32'(abort_at));
            check("abort_done", 32'(done), 32'd0);
            check("abort_sig", 32'(signature), 32'd0);
            @(negedge clk);
            check("abort_done_hold", 32'(done), 32'd0);
        end else begin
            check("run_cycles", 32'(cycles), 32'(EXP_LEN));
            check("done", 32'(done), 32'd1);
            check("signature", 32'(signature), 32'(exp_sig));
            if (mode == 0) check("sig_zero", 32'(signature), 32'd0);
            golden = exp_sig;
            #1 check("pass_hi", 32'(pass), 32'd1);
            golden = exp_sig ^ 16'h0100;
            #1 check("pass_lo", 32'(pass), 32'd0);
            @(negedge clk);
            check("sig_hold", 32'(signature), 32'(exp_sig));
        end
    endtask

    initial begin
        int          waited;
        logic [15:0] exp1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pat_o", 32'(pat_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sig", 32'(signature), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);

        do_run(2, 0, 0);
        golden = 16'h0000;
        do_run(0, 0, 0);
        do_run(2, 0, 10);
        do_run(2, 5, 0);
        do_run(1, 0, 0);

        // Short-run instance: a single absorb of resp=1.
        model_run(EXP_LEN1, 1, 1'b0);
        exp1 = sig_q.pop_front();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        waited = 0;
        while (!done1 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("dut1_done", 32'(done1), 32'd1);
        check("dut1_sig", 32'(signature1), 32'(exp1));
`ifndef CONE_BIST_EXHAUSTIVE_EN
        check("dut1_sig_const", 32'(signature1), 32'h0001);
`endif
        check("dut1_pat_o", 32'(pat_o1), 32'd0);
        golden1 = exp1;
        #1 check("dut1_pass_hi", 32'(pass1), 32'd1);
        golden1 = exp1 ^ 16'h0003;
        #1 check("dut1_pass_lo", 32'(pass1), 32'd0);

        // Asynchronous reset in the middle of a run, away from any clock edge.
        resp_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_pat_o", 32'(pat_o), 32'd0);
        check("arst_sig", 32'(signature), 32'd0);
        check("arst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
